// File: rtl/prewitt_pkg.sv
// Shared types and geometry helpers for the Prewitt scan controller.
package prewitt_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } scan_state_e;

  // Inputs that must be buffered ahead of the window centre: one full line plus two pixels.
  function automatic int unsigned lead_f(input int unsigned cols);
    return cols + 2;
  endfunction

  function automatic int unsigned total_f(input int unsigned rows, input int unsigned cols);
    return rows * cols;
  endfunction

endpackage

// File: rtl/raster_cnt.sv
// Column/row raster position counter with wrap at the frame edges.
module raster_cnt #(
  parameter int unsigned ROWS = 4,
  parameter int unsigned COLS = 5,
  parameter int unsigned CW   = $clog2(COLS),
  parameter int unsigned RW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      if (col_q == CW'(COLS - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(ROWS - 1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o = col_q;
  assign row_o = row_q;

endmodule

// File: rtl/prewitt_scan_ctrl.sv
// Scan controller for a 3x3 Prewitt filter: paces the pixel stream against the result
// stream so the window centre stays one line plus one pixel behind the newest input.
module prewitt_scan_ctrl
  import prewitt_pkg::*;
#(
  parameter int unsigned ROWS = 242,
  parameter int unsigned COLS = 247,
  localparam int unsigned TOTAL = total_f(ROWS, COLS),
  localparam int unsigned LEAD  = lead_f(COLS),
  localparam int unsigned CW    = $clog2(COLS),
  localparam int unsigned RW    = $clog2(ROWS),
  localparam int unsigned NW    = $clog2(TOTAL + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          lb_wr_en,
  output logic [CW-1:0] lb_addr,
  output logic          win_shift,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_border,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          busy,
  output logic          done
);

  scan_state_e   state_q;
  logic [NW-1:0] acc_q, emt_q;
  logic [NW-1:0] lag;
  logic          run, clr, in_xfer, out_xfer;
  logic [CW-1:0] in_col;
  logic [RW-1:0] unused_in_row;

  assign run = (state_q == StRun);
  assign clr = (state_q == StIdle) && start;
  assign lag = acc_q - emt_q;

  assign in_ready  = run && (acc_q < NW'(TOTAL)) && (lag < NW'(LEAD));
  // Once the whole frame is in, the remaining outputs drain without further input.
  assign out_valid = run && ((lag == NW'(LEAD)) ||
                             ((acc_q == NW'(TOTAL)) && (emt_q < NW'(TOTAL))));
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  assign win_shift = in_xfer;
  assign lb_wr_en  = in_xfer;
  assign lb_addr   = in_col;

  assign out_border = run && ((out_row == '0) || (out_row == RW'(ROWS - 1)) ||
                              (out_col == '0) || (out_col == CW'(COLS - 1)));
  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      acc_q   <= '0;
      emt_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            acc_q   <= '0;
            emt_q   <= '0;
          end
        end
        StRun: begin
          if (in_xfer) acc_q <= acc_q + 1'b1;
          if (out_xfer) begin
            emt_q <= emt_q + 1'b1;
            if (emt_q == NW'(TOTAL - 1)) state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  raster_cnt #(
    .ROWS(ROWS),
    .COLS(COLS),
    .CW  (CW),
    .RW  (RW)
  ) u_in_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(clr),
    .adv_i(in_xfer),
    .col_o(in_col),
    .row_o(unused_in_row)
  );

  raster_cnt #(
    .ROWS(ROWS),
    .COLS(COLS),
    .CW  (CW),
    .RW  (RW)
  ) u_out_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(clr),
    .adv_i(out_xfer),
    .col_o(out_col),
    .row_o(out_row)
  );

endmodule

// File: tb/tb_prewitt_scan_ctrl.sv
// Randomised bench for prewitt_scan_ctrl against a count-based frame model.
module tb_prewitt_scan_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 5;
  localparam int TOTAL = ROWS * COLS;
  localparam int LEAD  = COLS + 2;
  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);

  logic          clk = 1'b0;
  logic          rst_n, start, in_valid, out_ready;
  logic          in_ready, lb_wr_en, win_shift, out_valid, out_border, busy, done;
  logic [CW-1:0] lb_addr, out_col;
  logic [RW-1:0] out_row;

  always #5 clk = ~clk;

  prewitt_scan_ctrl #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lb_wr_en  (lb_wr_en),
    .lb_addr   (lb_addr),
    .win_shift (win_shift),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_border(out_border),
    .out_row   (out_row),
    .out_col   (out_col),
    .busy      (busy),
    .done      (done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase (0 idle, 1 running, 2 finished) plus pixel counts in/out.
  int m_st, m_acc, m_emt;
  int cyc = 0;
  int n_shift, n_out, n_done, n_flush, n_inner, cyc7, first_ov;

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit exp_in_ready();
    return (m_st == 1) && (m_acc < TOTAL) && (m_acc - m_emt < LEAD);
  endfunction

  function automatic bit exp_out_valid();
    return (m_st == 1) && ((m_acc - m_emt == LEAD) || (m_acc == TOTAL && m_emt < TOTAL));
  endfunction

  task automatic check_outputs();
    bit ir, ov, brd;
    int r, c;
    ir  = exp_in_ready();
    ov  = exp_out_valid();
    r   = (m_emt / COLS) % ROWS;
    c   = m_emt % COLS;
    brd = (m_st == 1) && (r == 0 || r == ROWS - 1 || c == 0 || c == COLS - 1);
    check_val("in_ready", int'(in_ready), int'(ir));
    check_val("out_valid", int'(out_valid), int'(ov));
    check_val("win_shift", int'(win_shift), int'(ir && in_valid));
    check_val("lb_wr_en", int'(lb_wr_en), int'(ir && in_valid));
    check_val("lb_addr", int'(lb_addr), m_acc % COLS);
    check_val("out_row", int'(out_row), r);
    check_val("out_col", int'(out_col), c);
    check_val("out_border", int'(out_border), int'(brd));
    check_val("busy", int'(busy), int'(m_st != 0));
    check_val("done", int'(done), int'(m_st == 2));
  endtask

  task automatic clear_stats();
    n_shift = 0; n_out = 0; n_done = 0; n_flush = 0; n_inner = 0;
    cyc7 = -1; first_ov = -1;
  endtask

  task automatic tick(input bit s, input bit iv, input bit ordy);
    bit ir, ov;
    start = s; in_valid = iv; out_ready = ordy;
    #2;
    check_outputs();
    ir = exp_in_ready();
    ov = exp_out_valid();
    if (win_shift === 1'b1) begin
      n_shift++;
      if (n_shift == LEAD) cyc7 = cyc;
    end
    if (out_valid === 1'b1 && first_ov < 0) first_ov = cyc;
    if (out_valid === 1'b1 && out_ready) begin
      n_out++;
      if (out_border === 1'b0) n_inner++;
      if (m_acc == TOTAL && m_acc - m_emt < LEAD && out_border === 1'b1 && win_shift === 1'b0)
        n_flush++;
    end
    if (done === 1'b1) n_done++;
    @(posedge clk);
    cyc++;
    case (m_st)
      0: if (s) begin m_st = 1; m_acc = 0; m_emt = 0; end
      1: begin
        if (iv && ir) m_acc++;
        if (ordy && ov) begin
          m_emt++;
          if (m_emt == TOTAL) m_st = 2;
        end
      end
      default: m_st = 0;
    endcase
    #1;
  endtask

  // mode 0: in_valid/out_ready held high; 1: random; 2: random plus stray start pulses.
  task automatic finish_frame(input int mode, input int budget);
    bit fin = 1'b0;
    for (int c = 0; c < budget && !fin; c++) begin
      if (mode == 0) tick(1'b0, 1'b1, 1'b1);
      else tick((mode == 2) ? 1'($urandom_range(0, 3) == 0) : 1'b0,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      if (n_done > 0 && m_st == 0) fin = 1'b1;
    end
    check_val("frame_timeout", int'(fin), 1);
    check_val("frame_done_pulses", n_done, 1);
    check_val("frame_outputs", n_out, TOTAL);
    check_val("frame_win_shifts", n_shift, TOTAL);
    check_val("frame_inner_pixels", n_inner, (ROWS - 2) * (COLS - 2));
    check_val("frame_flush_border", n_flush, TOTAL - (TOTAL - LEAD + 1));
    check_val("first_out_latency", first_ov - cyc7, 1);
  endtask

  task automatic run_frame(input int mode, input int budget);
    clear_stats();
    tick(1'b1, (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b1);
    finish_frame(mode, budget);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    m_st = 0; m_acc = 0; m_emt = 0;
    clear_stats();
    @(posedge clk);
    #1;
    check_outputs();
    rst_n = 1'b1;
    repeat (2) tick(1'b0, 1'b1, 1'b1);

    run_frame(0, 200);

    // Consumer stalled: the controller must stop after buffering exactly LEAD inputs.
    clear_stats();
    tick(1'b1, 1'b1, 1'b0);
    repeat (20) tick(1'b0, 1'b1, 1'b0);
    check_val("hold_accepts", n_shift, LEAD);
    check_val("hold_in_ready", int'(in_ready), 0);
    check_val("hold_out_row", int'(out_row), 0);
    check_val("hold_out_col", int'(out_col), 0);
    check_val("hold_out_border", int'(out_border), 1);
    finish_frame(1, 400);

    for (int f = 0; f < 3; f++) run_frame(1, 400);
    run_frame(2, 400);

    // Reset in the middle of a frame: outputs drop at once and no done pulse follows.
    clear_stats();
    tick(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < 100 && n_shift < 10; c++) tick(1'b0, 1'b1, 1'b1);
    check_val("pre_reset_inputs", n_shift, 10);
    in_valid = 1'b1;
    out_ready = 1'b1;
    rst_n = 1'b0;
    m_st = 0; m_acc = 0; m_emt = 0;
    #1;
    check_outputs();
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) tick(1'b0, 1'b1, 1'b1);
    check_val("abort_no_done", n_done, 0);
    check_val("abort_idle_busy", int'(busy), 0);

    run_frame(1, 400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
